// File: rtl/muldiv_alu.sv
// muldiv_alu: single-issue integer ALU with an iterative shift-add multiplier
// and an optional iterative restoring divider.
// Build option: define ALU_DIV_EN to include the divider. Without it the
// DIV/DIVU/REM/REMU opcodes complete in one cycle with result 0 and illegal=1.
module muldiv_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
    localparam logic [SHW-1:0]  CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ZERO = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Single-cycle operations; shift amount uses only the low log2(XLEN) bits.
    function automatic logic [XLEN-1:0] f_alu(input logic [3:0] f_op,
                                              input logic [XLEN-1:0] f_a,
                                              input logic [XLEN-1:0] f_b);
        logic [SHW-1:0]  f_sh;
        logic [XLEN-1:0] f_res;
        f_sh = f_b[SHW-1:0];
        case (f_op)
            OP_ADD:  f_res = f_a + f_b;
            OP_SUB:  f_res = f_a - f_b;
            OP_AND:  f_res = f_a & f_b;
            OP_OR:   f_res = f_a | f_b;
            OP_XOR:  f_res = f_a ^ f_b;
            OP_SLL:  f_res = f_a << f_sh;
            OP_SRL:  f_res = f_a >> f_sh;
            OP_SRA:  f_res = $signed(f_a) >>> f_sh;
            OP_SLT:  f_res = {{(XLEN-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
            OP_SLTU: f_res = {{(XLEN-1){1'b0}}, (f_a < f_b)};
            default: f_res = ALL_ZERO;
        endcase
        return f_res;
    endfunction

    // Two's-complement negate, used for divider magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] f_v);
        return ~f_v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t            r_state, w_state_nxt;
    logic [SHW-1:0]    r_cnt, w_cnt_nxt;
    logic [2*XLEN-1:0] r_prod, w_prod_nxt;
    logic [XLEN-1:0]   r_mcand, w_mcand_nxt;
    logic              r_is_hi, w_is_hi_nxt;
    logic [XLEN-1:0]   r_result, w_result_nxt;
    logic              r_illegal, w_illegal_nxt;
    logic              r_out_valid, r_zero, r_busy, r_in_ready;

    // One shift-add multiplier step: add multiplicand to the upper half when
    // the current multiplier bit is set, then shift the product right.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_step;
    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                         {1'b0, (r_prod[0] ? r_mcand : ALL_ZERO)};
    assign w_prod_step = {w_mul_sum, r_prod[XLEN-1:1]};

`ifdef ALU_DIV_EN
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] r_rem, w_rem_nxt;
    logic [XLEN-1:0] r_quo, w_quo_nxt;
    logic [XLEN-1:0] r_dvsr, w_dvsr_nxt;
    logic            r_neg_q, w_neg_q_nxt;
    logic            r_neg_r, w_neg_r_nxt;
    logic            r_want_rem, w_want_rem_nxt;

    // Operand signs at acceptance (op[0]=1 selects the unsigned variants).
    logic w_a_neg, w_b_neg;
    assign w_a_neg = ~op[0] & src_a[XLEN-1];
    assign w_b_neg = ~op[0] & src_b[XLEN-1];

    // One restoring-divide step: bring down the next dividend bit and
    // subtract the divisor when the partial remainder is large enough.
    logic [XLEN:0]   w_div_shift;
    logic [XLEN-1:0] w_div_diff, w_rem_step, w_quo_step;
    logic            w_div_ge;
    assign w_div_shift = {r_rem, r_quo[XLEN-1]};
    assign w_div_ge    = w_div_shift[XLEN] | (w_div_shift[XLEN-1:0] >= r_dvsr);
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_dvsr;
    assign w_rem_step  = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
    assign w_quo_step  = {r_quo[XLEN-2:0], w_div_ge};
`endif

    // Next-state and datapath next values for the IDLE/MUL/DIV/DONE sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_prod_nxt     = r_prod;
        w_mcand_nxt    = r_mcand;
        w_is_hi_nxt    = r_is_hi;
        w_result_nxt   = r_result;
        w_illegal_nxt  = r_illegal;
`ifdef ALU_DIV_EN
        w_rem_nxt      = r_rem;
        w_quo_nxt      = r_quo;
        w_dvsr_nxt     = r_dvsr;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_want_rem_nxt = r_want_rem;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if ((op == OP_MUL) || (op == OP_MULHU)) begin
                        w_state_nxt   = S_MUL;
                        w_cnt_nxt     = {SHW{1'b0}};
                        w_prod_nxt    = {ALL_ZERO, src_b};
                        w_mcand_nxt   = src_a;
                        w_is_hi_nxt   = op[0];
                        w_illegal_nxt = 1'b0;
                    end else if (op[3:2] == 2'b11) begin
`ifdef ALU_DIV_EN
                        w_illegal_nxt = 1'b0;
                        if (src_b == ALL_ZERO) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            w_state_nxt  = S_DONE;
                            w_result_nxt = op[1] ? src_a : ALL_ONES;
                        end else if (!op[0] && (src_a == MOST_NEG) && (src_b == ALL_ONES)) begin
                            // Signed overflow: quotient wraps to most-negative, remainder 0.
                            w_state_nxt  = S_DONE;
                            w_result_nxt = op[1] ? ALL_ZERO : MOST_NEG;
                        end else begin
                            w_state_nxt    = S_DIV;
                            w_cnt_nxt      = {SHW{1'b0}};
                            w_rem_nxt      = ALL_ZERO;
                            w_quo_nxt      = w_a_neg ? f_neg(src_a) : src_a;
                            w_dvsr_nxt     = w_b_neg ? f_neg(src_b) : src_b;
                            w_neg_q_nxt    = w_a_neg ^ w_b_neg;
                            w_neg_r_nxt    = w_a_neg;
                            w_want_rem_nxt = op[1];
                        end
`else
                        w_state_nxt   = S_DONE;
                        w_result_nxt  = ALL_ZERO;
                        w_illegal_nxt = 1'b1;
`endif
                    end else begin
                        w_state_nxt   = S_DONE;
                        w_result_nxt  = f_alu(op, src_a, src_b);
                        w_illegal_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                w_prod_nxt = w_prod_step;
                w_cnt_nxt  = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = r_is_hi ? w_prod_step[2*XLEN-1:XLEN] : w_prod_step[XLEN-1:0];
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    if (r_want_rem) begin
                        w_result_nxt = r_neg_r ? f_neg(w_rem_step) : w_rem_step;
                    end else begin
                        w_result_nxt = r_neg_q ? f_neg(w_quo_step) : w_quo_step;
                    end
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_illegal_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= {SHW{1'b0}};
            r_prod      <= {(2*XLEN){1'b0}};
            r_mcand     <= ALL_ZERO;
            r_is_hi     <= 1'b0;
            r_result    <= ALL_ZERO;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_prod      <= w_prod_nxt;
            r_mcand     <= w_mcand_nxt;
            r_is_hi     <= w_is_hi_nxt;
            r_result    <= w_result_nxt;
            r_illegal   <= w_illegal_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            r_zero      <= (w_state_nxt == S_DONE) && (w_result_nxt == ALL_ZERO);
            r_busy      <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV);
            r_in_ready  <= (w_state_nxt == S_IDLE);
        end
    end

`ifdef ALU_DIV_EN
    // Divider working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem      <= ALL_ZERO;
            r_quo      <= ALL_ZERO;
            r_dvsr     <= ALL_ZERO;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_want_rem <= 1'b0;
        end else begin
            r_rem      <= w_rem_nxt;
            r_quo      <= w_quo_nxt;
            r_dvsr     <= w_dvsr_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_want_rem <= w_want_rem_nxt;
        end
    end
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign busy      = r_busy;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_muldiv_alu.sv
// Self-checking bench for muldiv_alu: directed corner cases plus random
// operations on a 32-bit and a 16-bit instance, compared against an
// arithmetic reference model. Honours ALU_DIV_EN for the divide opcodes.
module tb_muldiv_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv32, iv16, out_ready;
    logic [3:0]  op;
    logic [31:0] a_s, b_s;
    logic        sel16;

    logic        rdy32, ov32, z32, bsy32, il32;
    logic [31:0] r32;
    logic        rdy16, ov16, z16, bsy16, il16;
    logic [15:0] r16;

    logic        m_ov, m_rdy, m_z, m_busy, m_ill;
    logic [63:0] m_res;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_alu #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .op(op),
        .src_a(a_s), .src_b(b_s), .out_valid(ov32), .out_ready(out_ready),
        .result(r32), .zero(z32), .busy(bsy32), .illegal(il32));

    muldiv_alu #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16), .op(op),
        .src_a(a_s[15:0]), .src_b(b_s[15:0]), .out_valid(ov16), .out_ready(out_ready),
        .result(r16), .zero(z16), .busy(bsy16), .illegal(il16));

    always_comb begin
        if (sel16) begin
            m_ov = ov16; m_rdy = rdy16; m_z = z16; m_busy = bsy16; m_ill = il16;
            m_res = {48'h0, r16};
        end else begin
            m_ov = ov32; m_rdy = rdy32; m_z = z32; m_busy = bsy32; m_ill = il32;
            m_res = {32'h0, r32};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values masked to xl bits.
    function automatic void model(input int xl, input logic [3:0] o,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic ill, output int lat);
        logic [63:0] mask;
        logic [63:0] prod;
        longint      sa, sb;
        int          sh;
        mask = (64'd1 << xl) - 64'd1;
        sa = longint'(a);
        if (a[xl-1]) sa = sa - (longint'(1) << xl);
        sb = longint'(b);
        if (b[xl-1]) sb = sb - (longint'(1) << xl);
        sh = int'(b % 64'(xl));
        r = 64'd0; ill = 1'b0; lat = 1;
        case (o)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = 64'(sa >>> sh);
            4'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: begin r = a * b; lat = xl + 1; end
            4'd11: begin prod = a * b; r = prod >> xl; lat = xl + 1; end
            default: begin
`ifdef ALU_DIV_EN
                if (b == 64'd0) begin
                    r = o[1] ? a : mask;
                end else if (!o[0] && (sa == -(longint'(1) << (xl - 1))) && (sb == -64'sd1)) begin
                    r = o[1] ? 64'd0 : a;
                end else begin
                    lat = xl + 1;
                    if (o[0]) r = o[1] ? (a % b) : (a / b);
                    else      r = o[1] ? 64'(sa % sb) : 64'(sa / sb);
                end
`else
                ill = 1'b1;
                r = 64'd0;
`endif
            end
        endcase
        r = r & mask;
    endfunction

    // Issue one request, hold the result for `hold` cycles, then release it.
    task automatic run(input bit w16, input logic [3:0] o, input logic [63:0] a_in,
                       input logic [63:0] b_in, input int hold, input string tag);
        int          xl, elat, lat, bcnt;
        logic [63:0] mask, a, b, er;
        logic        eil;
        xl   = w16 ? 16 : 32;
        mask = (64'd1 << xl) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        model(xl, o, a, b, er, eil, elat);
        sel16 = w16;
        @(negedge clk);
        chk($sformatf("%s.in_ready_idle", tag), {63'd0, m_rdy}, 64'd1);
        op = o; a_s = a[31:0]; b_s = b[31:0];
        iv32 = ~w16; iv16 = w16;
        @(posedge clk); #1;
        // Keep in_valid high and scramble operands: must be ignored until IDLE.
        op = 4'($urandom); a_s = $urandom; b_s = $urandom;
        lat = 1; bcnt = 0;
        while (!m_ov && lat < 200) begin
            if (m_busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s.latency", tag), 64'(lat), 64'(elat));
        chk($sformatf("%s.result", tag), m_res, er);
        chk($sformatf("%s.zero", tag), {63'd0, m_z}, {63'd0, (er == 64'd0)});
        chk($sformatf("%s.illegal", tag), {63'd0, m_ill}, {63'd0, eil});
        chk($sformatf("%s.busy_cycles", tag), 64'(bcnt), 64'(elat - 1));
        chk($sformatf("%s.busy_done", tag), {63'd0, m_busy}, 64'd0);
        chk($sformatf("%s.in_ready_done", tag), {63'd0, m_rdy}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.hold_valid%0d", tag, i), {63'd0, m_ov}, 64'd1);
            chk($sformatf("%s.hold_result%0d", tag, i), m_res, er);
        end
        iv32 = 1'b0; iv16 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("%s.rel_valid", tag), {63'd0, m_ov}, 64'd0);
        chk($sformatf("%s.rel_zero", tag), {63'd0, m_z}, 64'd0);
        chk($sformatf("%s.rel_in_ready", tag), {63'd0, m_rdy}, 64'd1);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick(input int xl);
        logic [63:0] mask;
        mask = (64'd1 << xl) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return mask;
            3:       return 64'd1 << (xl - 1);
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; iv32 = 1'b0; iv16 = 1'b0; out_ready = 1'b0;
        op = 4'd0; a_s = 32'd0; b_s = 32'd0; sel16 = 1'b0;
        #12;
        chk("rst.ov32", {63'd0, ov32}, 64'd0);
        chk("rst.rdy32", {63'd0, rdy32}, 64'd1);
        chk("rst.res32", {32'd0, r32}, 64'd0);
        chk("rst.flags32", {60'd0, z32, bsy32, il32, ov32}, 64'd0);
        chk("rst.rdy16", {63'd0, rdy16}, 64'd1);
        chk("rst.res16", {48'd0, r16}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(1'b0, 4'b0000, 64'd5, 64'd3, 3, "add");
        run(1'b0, 4'b1010, 64'h10000, 64'h10000, 1, "mul");
        run(1'b0, 4'b1011, 64'h10000, 64'h10000, 0, "mulhu");
        run(1'b0, 4'b1100, 64'hFFFFFFF9, 64'd2, 0, "div_m7_2");
        run(1'b0, 4'b1110, 64'hFFFFFFF9, 64'd2, 0, "rem_m7_2");
        run(1'b0, 4'b1100, 64'h80000000, 64'hFFFFFFFF, 0, "div_ovf");
        run(1'b0, 4'b1110, 64'h80000000, 64'hFFFFFFFF, 0, "rem_ovf");
        run(1'b0, 4'b1101, 64'd10, 64'd0, 0, "divu_by0");
        run(1'b0, 4'b1111, 64'd10, 64'd0, 0, "remu_by0");
        run(1'b0, 4'b1101, 64'd10, 64'd3, 0, "divu_10_3");

        // Reset ten cycles into a multiply: everything drops at once.
        sel16 = 1'b0;
        @(negedge clk);
        op = 4'b1010; a_s = 32'h1234; b_s = 32'h5678; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid.busy_before", {63'd0, bsy32}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", {63'd0, ov32}, 64'd0);
        chk("rst_mid.busy", {63'd0, bsy32}, 64'd0);
        chk("rst_mid.in_ready", {63'd0, rdy32}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1'b0, 4'b0001, 64'd5, 64'd3, 0, "sub_after_rst");

        run(1'b1, 4'b0111, 64'h8000, 64'd17, 0, "sra16");
        run(1'b1, 4'b1000, 64'hFFFE, 64'd1, 0, "slt16");

        for (int i = 0; i < 40; i++) begin
            run(1'b0, 4'($urandom_range(0, 15)), pick(32), pick(32),
                $urandom_range(0, 2), $sformatf("rnd32_%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            run(1'b1, 4'($urandom_range(0, 15)), pick(16), pick(16),
                $urandom_range(0, 1), $sformatf("rnd16_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
